i_cache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache for the rv32i fetch stage; the successor to the flat combinational instruction ROM.
- Parametrised in line size and line count; serves the fetch PC with a same-cycle hit path.
- On a miss: stalls fetch, refills one line word-by-word from a backing memory over a valid-beat handshake, then resumes.
- Supports whole-cache invalidate (fence.i) and hit/miss performance counters.

---
 rtl/i_cache_dm.sv | 126 ++++++++++++
 tb/tb_i_cache_dm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/i_cache_dm.sv
// Direct-mapped read-only instruction cache for the rv32i fetch stage.
// Same-cycle hit path; misses stall fetch and refill one line beat-by-beat.
module i_cache_dm #(
  parameter int unsigned DPW       = 32,
  parameter int unsigned LineWords = 4,
  parameter int unsigned NumLines  = 16,
  parameter int unsigned CntW      = 32
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic [DPW-1:0]  PCF,
  input  logic            fetch_req,
  input  logic            flush,
  output logic [DPW-1:0]  instr,
  output logic            StallF,
  output logic            mem_req,
  output logic [DPW-1:0]  mem_addr,
  input  logic            mem_rvalid,
  input  logic [DPW-1:0]  mem_rdata,
  output logic [CntW-1:0] hit_cnt,
  output logic [CntW-1:0] miss_cnt
);

  localparam int unsigned BW   = $clog2(LineWords);
  localparam int unsigned OffW = BW + 2;
  localparam int unsigned IdxW = $clog2(NumLines);
  localparam int unsigned TagW = DPW - IdxW - OffW;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, state_nx;

  logic [DPW-1:0]  data_arr [NumLines][LineWords];
  logic [TagW-1:0] tag_arr  [NumLines];
  logic [NumLines-1:0] valid;

  logic [BW-1:0]   word, beat;
  logic [IdxW-1:0] idx, idx_l;
  logic [TagW-1:0] tag, tag_l;
  logic            flush_pend;
  logic            hit, do_hit, do_miss, beat_we, last_beat;

  assign word = PCF[OffW-1:2];
  assign idx  = PCF[OffW+IdxW-1:OffW];
  assign tag  = PCF[DPW-1:OffW+IdxW];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    StallF    = 1'b0;
    instr     = '0;
    hit       = 1'b0;
    do_hit    = 1'b0;
    do_miss   = 1'b0;
    beat_we   = 1'b0;
    last_beat = 1'b0;
    case (state)
      IDLE: begin
        hit = fetch_req && valid[idx] && (tag_arr[idx] == tag);
        if (hit) begin
          instr  = data_arr[idx][word];
          do_hit = 1'b1;
        end else if (fetch_req) begin
          StallF   = 1'b1;
          do_miss  = 1'b1;
          state_nx = REFILL;
        end
      end
      REFILL: begin
        StallF = 1'b1;
        if (mem_rvalid) begin
          beat_we = 1'b1;
          if (beat == BW'(LineWords - 1)) begin
            last_beat = 1'b1;
            state_nx  = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line storage and latched miss coordinates carry no reset; valid gates all reads.
  always_ff @(posedge clk) begin
    if (do_miss) begin
      idx_l <= idx;
      tag_l <= tag;
    end
    if (beat_we)   data_arr[idx_l][beat] <= mem_rdata;
    if (last_beat) tag_arr[idx_l] <= tag_l;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid      <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      beat       <= '0;
      flush_pend <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      if (flush) valid <= '0;
      if (flush && state == REFILL) flush_pend <= 1'b1;
      if (do_miss) begin
        mem_req  <= 1'b1;
        mem_addr <= {PCF[DPW-1:OffW], {OffW{1'b0}}};
        beat     <= '0;
      end
      if (beat_we) beat <= beat + 1'b1;
      // A flush landing on the final beat must also keep the line invalid.
      if (last_beat) begin
        valid[idx_l] <= !flush_pend && !flush;
        mem_req      <= 1'b0;
        flush_pend   <= 1'b0;
      end
      if (do_hit && hit_cnt != '1)   hit_cnt  <= hit_cnt + 1'b1;
      if (do_miss && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_i_cache_dm.sv
// Directed self-checking bench for i_cache_dm: a default-sized instance plus a
// CntW=2 instance for counter saturation.
module tb_i_cache_dm;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [31:0] PCF = '0;
  logic        fetch_req = 1'b0, flush = 1'b0;
  logic [31:0] instr, mem_addr;
  logic        StallF, mem_req;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] hit_cnt, miss_cnt;

  logic [31:0] s_pc = '0;
  logic        s_fetch = 1'b0, s_flush = 1'b0;
  logic [31:0] s_instr, s_mem_addr;
  logic        s_stall, s_mem_req;
  logic        s_rvalid = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_hit, s_miss;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] W0 = 32'h00022203, W1 = 32'h0042A283,
                          W2 = 32'h00C3A383, W3 = 32'h01042403;
  localparam logic [31:0] A0 = 32'h11110000, A1 = 32'h11110001,
                          A2 = 32'h11110002, A3 = 32'h11110003;

  always #5 clk = ~clk;

  i_cache_dm #(.DPW(32), .LineWords(4), .NumLines(16), .CntW(32)) u_dut (
    .clk(clk), .arst_n(arst_n), .PCF(PCF), .fetch_req(fetch_req), .flush(flush),
    .instr(instr), .StallF(StallF), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  i_cache_dm #(.DPW(32), .LineWords(4), .NumLines(16), .CntW(2)) u_sat (
    .clk(clk), .arst_n(arst_n), .PCF(s_pc), .fetch_req(s_fetch), .flush(s_flush),
    .instr(s_instr), .StallF(s_stall), .mem_req(s_mem_req), .mem_addr(s_mem_addr),
    .mem_rvalid(s_rvalid), .mem_rdata(s_rdata),
    .hit_cnt(s_hit), .miss_cnt(s_miss)
  );

  // Drives four beats starting at the current negedge; returns at the negedge
  // after the last beat with mem_rvalid low. flush pulses alongside beat fb.
  task automatic refill(input logic [31:0] b0, b1, b2, b3, input int fb);
    logic [31:0] w [4];
    w[0] = b0; w[1] = b1; w[2] = b2; w[3] = b3;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = w[i];
      flush      = (i == fb);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #1;
    total++; if (StallF !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", StallF); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
    total++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    @(negedge clk); @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    @(negedge clk);
    fetch_req = 1'b1; PCF = 32'h0;
    #1;
    total++; if (StallF !== 1'b1) begin bad++; $display("FAIL cold_stall got=%b exp=1", StallF); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL cold_instr0 got=%h exp=0", instr); end
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL cold_mem_req got=%b exp=1", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL cold_mem_addr got=%h exp=0", mem_addr); end
    refill(W0, W1, W2, W3, -1);
    #1;
    total++; if (instr !== W0) begin bad++; $display("FAIL cold_instr got=%h exp=%h", instr, W0); end
    total++; if (StallF !== 1'b0) begin bad++; $display("FAIL cold_resume got=%b exp=0", StallF); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL cold_req_drop got=%b exp=0", mem_req); end
    total++; if (miss_cnt !== 32'd1) begin bad++; $display("FAIL cold_miss_cnt got=%0d exp=1", miss_cnt); end
  endtask

  task automatic test_seq_hits();
    logic [31:0] exp_w [3];
    exp_w[0] = W1; exp_w[1] = W2; exp_w[2] = W3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      PCF = 32'(4 * (i + 1));
      #1;
      total++; if (instr !== exp_w[i] || StallF !== 1'b0) begin bad++; $display("FAIL seq_hit%0d got=%h/%b exp=%h/0", i, instr, StallF, exp_w[i]); end
    end
    @(negedge clk);
    fetch_req = 1'b0;
    #1;
    total++; if (hit_cnt !== 32'd4) begin bad++; $display("FAIL seq_hit_cnt got=%0d exp=4", hit_cnt); end
    total++; if (instr !== 32'h0 || StallF !== 1'b0) begin bad++; $display("FAIL idle_out got=%h/%b exp=0/0", instr, StallF); end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    fetch_req = 1'b1; PCF = 32'h100;
    #1;
    total++; if (StallF !== 1'b1) begin bad++; $display("FAIL conf_stall got=%b exp=1", StallF); end
    @(negedge clk);
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL conf_addr got=%h exp=00000100", mem_addr); end
    total++; if (miss_cnt !== 32'd2) begin bad++; $display("FAIL conf_miss_cnt got=%0d exp=2", miss_cnt); end
    refill(A0, A1, A2, A3, -1);
    #1;
    total++; if (instr !== A0) begin bad++; $display("FAIL conf_instr got=%h exp=%h", instr, A0); end
    @(negedge clk);
    PCF = 32'h0;
    #1;
    total++; if (StallF !== 1'b1) begin bad++; $display("FAIL conf_back_stall got=%b exp=1", StallF); end
    @(negedge clk);
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL conf_back_addr got=%h exp=0", mem_addr); end
    total++; if (miss_cnt !== 32'd3) begin bad++; $display("FAIL conf_back_miss got=%0d exp=3", miss_cnt); end
    refill(W0, W1, W2, W3, -1);
    #1;
    total++; if (instr !== W0) begin bad++; $display("FAIL conf_back_instr got=%h exp=%h", instr, W0); end
    @(negedge clk);
    fetch_req = 1'b0;
    #1;
    total++; if (hit_cnt !== 32'd6) begin bad++; $display("FAIL conf_hit_cnt got=%0d exp=6", hit_cnt); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    fetch_req = 1'b1; PCF = 32'h4; flush = 1'b1;
    #1;
    total++; if (instr !== W1 || StallF !== 1'b0) begin bad++; $display("FAIL flush_same_hit got=%h/%b exp=%h/0", instr, StallF, W1); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++; if (StallF !== 1'b1) begin bad++; $display("FAIL flush_miss got=%b exp=1", StallF); end
    @(negedge clk);
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL flush_addr got=%h exp=0", mem_addr); end
    refill(W0, W1, W2, W3, -1);
    #1;
    total++; if (instr !== W1) begin bad++; $display("FAIL flush_refetch got=%h exp=%h", instr, W1); end
    @(negedge clk);
    PCF = 32'h100;
    #1;
    total++; if (StallF !== 1'b1) begin bad++; $display("FAIL fpend_miss got=%b exp=1", StallF); end
    @(negedge clk);
    refill(A0, A1, A2, A3, 2);
    #1;
    total++; if (StallF !== 1'b1) begin bad++; $display("FAIL fpend_remiss got=%b exp=1", StallF); end
    @(negedge clk);
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL fpend_addr got=%h exp=00000100", mem_addr); end
    refill(A0, A1, A2, A3, -1);
    #1;
    total++; if (instr !== A0) begin bad++; $display("FAIL fpend_instr got=%h exp=%h", instr, A0); end
    @(negedge clk);
    fetch_req = 1'b0;
    #1;
    total++; if (hit_cnt !== 32'd9 || miss_cnt !== 32'd6) begin bad++; $display("FAIL flush_cnt got=%0d/%0d exp=9/6", hit_cnt, miss_cnt); end
  endtask

  task automatic test_reset_mid_refill();
    @(negedge clk);
    fetch_req = 1'b1; PCF = 32'h200;
    @(negedge clk);
    total++; if (mem_addr !== 32'h200 || mem_req !== 1'b1) begin bad++; $display("FAIL mid_req got=%h/%b exp=00000200/1", mem_addr, mem_req); end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD0000;
    @(negedge clk);
    mem_rdata = 32'hDEAD0001;
    @(negedge clk);
    arst_n = 1'b0; fetch_req = 1'b0; mem_rdata = 32'hDEAD0002;
    #1;
    total++; if (mem_req !== 1'b0 || StallF !== 1'b0) begin bad++; $display("FAIL mid_rst_out got=%b/%b exp=0/0", mem_req, StallF); end
    total++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL mid_rst_addr got=%h exp=0", mem_addr); end
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    mem_rdata = 32'hDEAD0003;
    @(negedge clk);
    mem_rvalid = 1'b0;
    fetch_req = 1'b1; PCF = 32'h0;
    #1;
    total++; if (StallF !== 1'b1) begin bad++; $display("FAIL post_rst_miss got=%b exp=1", StallF); end
    @(negedge clk);
    total++; if (mem_addr !== 32'h0 || miss_cnt !== 32'd1) begin bad++; $display("FAIL post_rst_req got=%h/%0d exp=0/1", mem_addr, miss_cnt); end
    refill(W0, W1, W2, W3, -1);
    #1;
    total++; if (instr !== W0) begin bad++; $display("FAIL post_rst_instr got=%h exp=%h", instr, W0); end
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  task automatic test_saturation();
    logic [31:0] w [4];
    w[0] = 32'hCAFE0000; w[1] = 32'hCAFE0001; w[2] = 32'hCAFE0002; w[3] = 32'hCAFE0003;
    @(negedge clk);
    s_fetch = 1'b1; s_pc = 32'h0;
    @(negedge clk);
    total++; if (s_mem_req !== 1'b1 || s_miss !== 2'd1) begin bad++; $display("FAIL sat_miss got=%b/%0d exp=1/1", s_mem_req, s_miss); end
    for (int i = 0; i < 4; i++) begin
      s_rvalid = 1'b1; s_rdata = w[i];
      @(negedge clk);
    end
    s_rvalid = 1'b0;
    #1;
    total++; if (s_instr !== w[0]) begin bad++; $display("FAIL sat_instr got=%h exp=%h", s_instr, w[0]); end
    repeat (5) @(negedge clk);
    total++; if (s_hit !== 2'd3) begin bad++; $display("FAIL sat_hit5 got=%0d exp=3", s_hit); end
    @(negedge clk);
    total++; if (s_hit !== 2'd3) begin bad++; $display("FAIL sat_hit_hold got=%0d exp=3", s_hit); end
    s_fetch = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_seq_hits();
    test_conflict();
    test_flush();
    test_reset_mid_refill();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
